// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined adder: configuration helpers
// and the per-stage control bundle carried alongside each segment's sum bits.
package adder_pkg;

  // Control state registered by every segment stage.
  typedef struct packed {
    logic vld;
    logic carry;
    logic ovf;
  } seg_ctl_t;

  localparam int SEG_CTL_W = $bits(seg_ctl_t);

  function automatic bit cfg_ok(input int width, input int seg_w);
    return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

  function automatic int seg_count(input int width, input int seg_w);
    return (seg_w > 0) ? (width / seg_w) : 1;
  endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One pipeline stage of the segmented adder: adds one SEG_W-bit segment with the
// incoming carry and registers sum, carry and valid; holds everything on ~advance.
module adder_seg_stage
  import adder_pkg::*;
#(
  parameter int SEG_W = 4,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             vld_in,
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             c_in,
  output logic [SEG_W-1:0] sum_seg,
  output logic             c_out,
  output logic             ovf,
  output logic             vld
);

  logic [SEG_W:0]   total;
  logic             c_msb;
  logic             ovf_c;
  seg_ctl_t         ctl_p;
  logic [SEG_W-1:0] sum_p;

  assign total = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, c_in};
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign c_msb = a_seg[SEG_W-1] ^ b_seg[SEG_W-1] ^ total[SEG_W-1];
  assign ovf_c = c_msb ^ total[SEG_W];

  // Stage register: bubbles advance the valid bit but leave data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_p <= '0;
      sum_p <= '0;
    end else if (advance) begin
      ctl_p.vld <= vld_in;
      if (vld_in) begin
        ctl_p.carry <= total[SEG_W];
        ctl_p.ovf   <= LAST ? ovf_c : 1'b0;
        sum_p       <= total[SEG_W-1:0];
      end
    end
  end

  assign sum_seg = sum_p;
  assign c_out   = ctl_p.carry;
  assign ovf     = ctl_p.ovf;
  assign vld     = ctl_p.vld;

endmodule

// File: rtl/pipelined_adder_seg.sv
// Segmented ripple-carry adder/subtractor, one pipeline stage per SEG_W-bit segment,
// with a valid/ready handshake and a global enable that freezes the whole pipeline.
module pipelined_adder_seg
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = seg_count(WIDTH, SEG_W);

  if (!cfg_ok(WIDTH, SEG_W)) begin : g_cfg_err
    $error("pipelined_adder_seg: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [NSEG-1:0]  ovf_vec;

  // A full output that is not being taken stalls every stage at once.
  assign advance  = en & ~(out_valid & ~out_ready);
  assign in_ready = advance;

  // Subtraction is folded into the operands at accept: A + ~B + 1.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int RW = WIDTH - k * SEG_W;

    logic [RW-1:0]            src_a;
    logic [RW-1:0]            src_b;
    logic                     c_in;
    logic                     vld_in;
    logic [SEG_W-1:0]         sum_seg;
    logic                     c_out;
    logic                     ovf_seg;
    logic                     vld;
    logic [(k+1)*SEG_W-1:0]   full;

    if (k == 0) begin : g_head
      assign src_a  = a;
      assign src_b  = b_eff;
      assign c_in   = c0;
      assign vld_in = in_valid;
      assign full   = sum_seg;
    end else begin : g_body
      logic [k*SEG_W-1:0] lo_p;

      assign src_a  = g_seg[k-1].g_fwd.opa_p;
      assign src_b  = g_seg[k-1].g_fwd.opb_p;
      assign c_in   = g_seg[k-1].c_out;
      assign vld_in = g_seg[k-1].vld;

      // Completed lower segments ride along so sum only ever shows whole results.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lo_p <= '0;
        end else if (advance && vld_in) begin
          lo_p <= g_seg[k-1].full;
        end
      end

      assign full = {sum_seg, lo_p};
    end

    // Operand delay line: only the segments still to be added move forward.
    if (RW > SEG_W) begin : g_fwd
      logic [RW-SEG_W-1:0] opa_p;
      logic [RW-SEG_W-1:0] opb_p;

      always_ff @(posedge clk) begin
        if (advance && vld_in) begin
          opa_p <= src_a[RW-1:SEG_W];
          opb_p <= src_b[RW-1:SEG_W];
        end
      end
    end

    adder_seg_stage #(
      .SEG_W (SEG_W),
      .LAST  (k == NSEG - 1)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (advance),
      .vld_in  (vld_in),
      .a_seg   (src_a[SEG_W-1:0]),
      .b_seg   (src_b[SEG_W-1:0]),
      .c_in    (c_in),
      .sum_seg (sum_seg),
      .c_out   (c_out),
      .ovf     (ovf_seg),
      .vld     (vld)
    );

    // Only the last stage produces a non-zero overflow flag.
    assign ovf_vec[k] = ovf_seg;
  end

  assign out_valid = g_seg[NSEG-1].vld;
  assign sum       = g_seg[NSEG-1].full;
  assign cout      = g_seg[NSEG-1].c_out;
  assign ovf       = |ovf_vec;

endmodule

// File: tb/tb_pipelined_adder_seg.sv
// Self-checking bench for pipelined_adder_seg (WIDTH=8, SEG_W=4): directed cases,
// backpressure/enable stalls, async reset, and randomized traffic against a queue model.
module tb_pipelined_adder_seg;

  localparam int WIDTH = 8;
  localparam int SEG_W = 4;
  localparam int NSEG  = WIDTH / SEG_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  always #5 clk = ~clk;

  pipelined_adder_seg #(
    .WIDTH (WIDTH),
    .SEG_W (SEG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               rem;
  } item_t;

  item_t q[$];

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic item_t ref_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                                   input logic xc, input logic xs);
    item_t it;
    int ua, ub, sa, sb, r, sr;
    ua = int'(xa);
    ub = int'(xb);
    sa = int'($signed(xa));
    sb = int'($signed(xb));
    if (xs) begin
      r       = ua - ub;
      sr      = sa - sb;
      it.cout = (ua >= ub);
    end else begin
      r       = ua + ub + int'(xc);
      sr      = sa + sb + int'(xc);
      it.cout = (r > 255);
    end
    it.sum = 8'(r & 255);
    it.ovf = (sr < -128) || (sr > 127);
    it.rem = NSEG - 1;
    return it;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic xc, input logic xs);
    in_valid = iv;
    a        = xa;
    b        = xb;
    cin      = xc;
    sub      = xs;
  endtask

  task automatic drive_rand(input logic iv);
    drive(iv, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // One clock: compare against the model, update the model, then step past the edge.
  task automatic tick();
    logic m_valid, m_adv;
    #1;
    m_valid = (q.size() > 0) && (q[0].rem == 0);
    m_adv   = en && !(m_valid && !out_ready);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(m_adv));
    if (m_valid) begin
      chk("sum", 32'(sum), 32'(q[0].sum));
      chk("cout", 32'(cout), 32'(q[0].cout));
      chk("ovf", 32'(ovf), 32'(q[0].ovf));
    end
    if (m_adv) begin
      if (m_valid) void'(q.pop_front());
      foreach (q[i]) q[i].rem = q[i].rem - 1;
      if (in_valid) q.push_back(ref_op(a, b, cin, sub));
    end
    @(posedge clk);
    #1;
  endtask

  // Single op into an empty pipeline; result must appear exactly two cycles later.
  task automatic directed(input string tag, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xc, input logic xs, input logic [WIDTH-1:0] esum,
                          input logic ecout, input logic eovf);
    drive(1'b1, xa, xb, xc, xs);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'(1'b1));
    chk({tag, "_sum"}, 32'(sum), 32'(esum));
    chk({tag, "_cout"}, 32'(cout), 32'(ecout));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_sum", 32'(sum), 32'(8'h00));
    chk("rst_cout", 32'(cout), 32'(1'b0));
    chk("rst_ovf", 32'(ovf), 32'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("add_ovf", 8'h3C, 8'h4A, 1'b0, 1'b0, 8'h86, 1'b0, 1'b1);
    directed("sub_borrow", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    directed("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    directed("carry_ripple", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Back-to-back add beats at full throughput.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();

    // Backpressure: fill the pipeline, then hold it stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_rand(1'b1);
      tick();
    end
    // Enable low: no drain even with the consumer ready.
    out_ready = 1'b1;
    en        = 1'b0;
    repeat (3) begin
      drive_rand(1'b1);
      tick();
    end
    en = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (4) tick();

    // Randomized traffic with bubbles, stalls and mixed add/sub.
    for (int i = 0; i < 300; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      drive_rand($urandom_range(0, 9) < 7);
      tick();
    end
    en        = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (4) tick();
    chk("drained", 32'(q.size()), 32'(0));

    // Asynchronous reset with two ops in flight.
    drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h56, 8'h78, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("arst_sum", 32'(sum), 32'(8'h00));
    chk("arst_cout", 32'(cout), 32'(1'b0));
    chk("arst_ovf", 32'(ovf), 32'(1'b0));
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) tick();
    directed("post_rst", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
